// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - funct3 encodings, FSM state type and access legality helper
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Stores have no unsigned variants, so BU/HU encodings are only legal on loads.
    function automatic logic f3_legal(input logic wr_en, input logic [2:0] f3);
        logic sized;
        sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (wr_en) begin
            return sized;
        end
        return sized || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response channel bundle between MEM stage and data memory
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr_en;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        output req_wr_en,
        output req_funct3,
        output req_wdata,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_wr_en,
        input  req_funct3,
        input  req_wdata,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// rtl/data_mem_responder_mem_lane_align.sv - byte/half/word lane extract for loads and lane merge for stores
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    always_comb begin
        lane_b     = word[{byte_off, 3'b000} +: 8];
        lane_h     = byte_off[1] ? word[31:16] : word[15:0];
        // funct3[2] marks the unsigned load variants
        sext       = ~funct3[2];
        load_data  = '0;
        store_word = word;
        misalign   = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                load_data = {{24{sext & lane_b[7]}}, lane_b};
                store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            2'b01: begin
                load_data = {{16{sext & lane_h[15]}}, lane_h};
                store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
                misalign = byte_off[0];
            end
            2'b10: begin
                load_data  = word;
                store_word = wdata;
                misalign   = |byte_off;
            end
            default: begin
                load_data  = '0;
                store_word = word;
                misalign   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - stallable data memory with wait states, RV32I lane rules and fault reporting
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 256,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int          LOGSIZE    = $clog2(SIZE);
    localparam logic [3:0]  CNT_LOAD   = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * SIZE);

    logic [WIDTH-1:0] mem [SIZE];

    state_t      state;
    logic [3:0]  cnt;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_wr_en;
    logic [2:0]  cap_funct3;

    logic               accept;
    logic               do_access;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic               acc_wr_en;
    logic [2:0]         acc_funct3;
    logic [LOGSIZE-1:0] acc_idx;
    logic               acc_err;
    logic [31:0]        load_data;
    logic [31:0]        store_word;
    logic               misalign;

    assign accept = (state == IDLE) && bus.req_valid;

    // With zero wait states the access happens on the accept edge, so it must see the live request.
    assign acc_addr   = (state == IDLE) ? bus.req_addr   : cap_addr;
    assign acc_wdata  = (state == IDLE) ? bus.req_wdata  : cap_wdata;
    assign acc_wr_en  = (state == IDLE) ? bus.req_wr_en  : cap_wr_en;
    assign acc_funct3 = (state == IDLE) ? bus.req_funct3 : cap_funct3;
    assign acc_idx    = acc_addr[LOGSIZE+1:2];

    assign do_access = (LATENCY == 0) ? accept : ((state == WAIT) && (cnt == 4'd0));

    assign acc_err = (acc_addr >= ADDR_LIMIT)
                   || !f3_legal(acc_wr_en, acc_funct3)
                   || misalign;

    mem_lane_align u_lane_align (
        .word       (32'(mem[acc_idx])),
        .byte_off   (acc_addr[1:0]),
        .funct3     (acc_funct3),
        .wdata      (acc_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .misalign   (misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (do_access) begin
                rdata_q <= (acc_err || acc_wr_en) ? 32'h0 : load_data;
                err_q   <= acc_err;
            end
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Array and captured request carry no reset; a reset on the write edge still suppresses the store.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_addr   <= bus.req_addr;
            cap_wdata  <= bus.req_wdata;
            cap_wr_en  <= bus.req_wr_en;
            cap_funct3 <= bus.req_funct3;
        end
        if (do_access && acc_wr_en && !acc_err && !reset) begin
            mem[acc_idx] <= WIDTH'(store_word);
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder with LATENCY=2 and LATENCY=0 builds
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.WIDTH(32), .SIZE(256), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_mem_responder #(.WIDTH(32), .SIZE(256), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat);
        int n;
        n = 0;
        bus.req_valid  = 1'b1;
        bus.req_wr_en  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
    endtask

    task automatic end_resp;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
            bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_l2 got ready=%b valid=%b rdata=%h err=%b, expected 1 0 00000000 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        vectors++;
        if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0 ||
            bus0.resp_rdata !== 32'h0 || bus0.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_l0 got ready=%b valid=%b rdata=%h err=%b, expected 1 0 00000000 0",
                     bus0.req_ready, bus0.resp_valid, bus0.resp_rdata, bus0.resp_err);
        end
    endtask

    task automatic test_store_load;
        vec_t v[$];
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        v.push_back('{1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
        v.push_back('{1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
        foreach (v[i]) begin
            sb.push_back('{v[i].rd, v[i].err});
            run_txn(v[i].wr, v[i].f3, v[i].addr, v[i].wd, rd, er, lat);
            e = sb.pop_front();
            vectors++;
            if (rd !== e.rd || er !== e.err || lat !== 2) begin
                miscompares++;
                $display("FAIL store_load[%0d] got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=2",
                         i, rd, er, lat, e.rd, e.err);
            end
            end_resp();
        end
    endtask

    task automatic test_lanes;
        vec_t v[$];
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        v.push_back('{1'b1, F3_B,  32'h11, 32'hFFFFFF55, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0});
        v.push_back('{1'b0, F3_B,  32'h11, 32'h0,        32'h00000055, 1'b0});
        v.push_back('{1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0});
        v.push_back('{1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0});
        v.push_back('{1'b0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0});
        v.push_back('{1'b0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0});
        v.push_back('{1'b1, F3_H,  32'h10, 32'hFFFF1234, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h10, 32'h0,        32'hDEAD1234, 1'b0});
        v.push_back('{1'b0, F3_H,  32'h10, 32'h0,        32'h00001234, 1'b0});
        foreach (v[i]) begin
            sb.push_back('{v[i].rd, v[i].err});
            run_txn(v[i].wr, v[i].f3, v[i].addr, v[i].wd, rd, er, lat);
            e = sb.pop_front();
            vectors++;
            if (rd !== e.rd || er !== e.err || lat !== 2) begin
                miscompares++;
                $display("FAIL lanes[%0d] got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=2",
                         i, rd, er, lat, e.rd, e.err);
            end
            end_resp();
        end
    endtask

    task automatic test_faults;
        vec_t v[$];
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        v.push_back('{1'b0, F3_W,   32'h12,  32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, F3_H,   32'h13,  32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, F3_W,   32'h400, 32'h0BADF00D, 32'h0,        1'b1});
        v.push_back('{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, F3_BU,  32'h10,  32'hFFFFFFFF, 32'h0,        1'b1});
        v.push_back('{1'b1, F3_H,   32'h11,  32'hFFFFFFFF, 32'h0,        1'b1});
        v.push_back('{1'b0, F3_W,   32'h10,  32'h0,        32'hDEAD1234, 1'b0});
        v.push_back('{1'b1, F3_W,   32'h3FC, 32'hA5A5A5A5, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,   32'h3FC, 32'h0,        32'hA5A5A5A5, 1'b0});
        v.push_back('{1'b0, F3_BU,  32'h3FF, 32'h0,        32'h000000A5, 1'b0});
        v.push_back('{1'b0, F3_W,   32'h400, 32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, F3_W,   32'h0,   32'h0,        32'hDEAD1234, 1'b1});
        v[11] = '{1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD1234, 1'b0};
        foreach (v[i]) begin
            sb.push_back('{v[i].rd, v[i].err});
            run_txn(v[i].wr, v[i].f3, v[i].addr, v[i].wd, rd, er, lat);
            e = sb.pop_front();
            vectors++;
            if (rd !== e.rd || er !== e.err || lat !== 2) begin
                miscompares++;
                $display("FAIL faults[%0d] got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=2",
                         i, rd, er, lat, e.rd, e.err);
            end
            end_resp();
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        sb.push_back('{32'hDEAD1234, 1'b0});
        bus.resp_ready = 1'b0;
        run_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rd || er !== e.err || lat !== 2) begin
            miscompares++;
            $display("FAIL bp_first got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=2",
                     rd, er, lat, e.rd, e.err);
        end
        // a competing store presented while busy must be ignored
        bus.req_valid = 1'b1;
        bus.req_wr_en = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr = 32'h10;
        bus.req_wdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rd ||
                bus.resp_err !== e.err || bus.req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got valid=%b rdata=%h err=%b ready=%b, expected 1 %h %b 0",
                         c, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready, e.rd, e.err);
            end
        end
        bus.req_valid = 1'b0;
        end_resp();
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release got ready=%b valid=%b, expected ready=1 valid=0",
                     bus.req_ready, bus.resp_valid);
        end
        sb.push_back('{32'hDEAD1234, 1'b0});
        run_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rd || er !== e.err) begin
            miscompares++;
            $display("FAIL bp_ignored_store got rdata=%h err=%b, expected rdata=%h err=%b",
                     rd, er, e.rd, e.err);
        end
        end_resp();
    endtask

    task automatic test_reset_wait;
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        sb.push_back('{32'h0, 1'b0});
        run_txn(1'b1, F3_W, 32'h20, 32'hCAFEF00D, rd, er, lat);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rd || er !== e.err || lat !== 2) begin
            miscompares++;
            $display("FAIL rw_prefill got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=2",
                     rd, er, lat, e.rd, e.err);
        end
        end_resp();
        bus.req_valid  = 1'b1;
        bus.req_wr_en  = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        vectors++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_in_wait got ready=%b valid=%b, expected ready=0 valid=0",
                     bus.req_ready, bus.resp_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_after_reset got ready=%b valid=%b, expected ready=1 valid=0",
                     bus.req_ready, bus.resp_valid);
        end
        repeat (4) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rw_no_resp got valid=%b, expected 0", bus.resp_valid);
            end
        end
        sb.push_back('{32'hCAFEF00D, 1'b0});
        run_txn(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rd || er !== e.err || lat !== 2) begin
            miscompares++;
            $display("FAIL rw_readback got rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=2",
                     rd, er, lat, e.rd, e.err);
        end
        end_resp();
    endtask

    task automatic test_latency0;
        vec_t v[$];
        exp_t e;
        v.push_back('{1'b1, F3_W,  32'h40, 32'h11111111, 32'h0,        1'b0});
        v.push_back('{1'b1, F3_W,  32'h44, 32'h22222222, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h40, 32'h0,        32'h11111111, 1'b0});
        v.push_back('{1'b0, F3_W,  32'h44, 32'h0,        32'h22222222, 1'b0});
        v.push_back('{1'b0, F3_HU, 32'h46, 32'h0,        32'h00002222, 1'b0});
        v.push_back('{1'b1, F3_B,  32'h47, 32'h00000080, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h44, 32'h0,        32'h80222222, 1'b0});
        v.push_back('{1'b0, F3_W,  32'h46, 32'h0,        32'h0,        1'b1});
        bus0.resp_ready = 1'b1;
        foreach (v[i]) begin
            vectors++;
            if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL l0_idle[%0d] got ready=%b valid=%b, expected ready=1 valid=0",
                         i, bus0.req_ready, bus0.resp_valid);
            end
            bus0.req_valid  = 1'b1;
            bus0.req_wr_en  = v[i].wr;
            bus0.req_funct3 = v[i].f3;
            bus0.req_addr   = v[i].addr;
            bus0.req_wdata  = v[i].wd;
            sb.push_back('{v[i].rd, v[i].err});
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (bus0.resp_valid !== 1'b1 || bus0.req_ready !== 1'b0 ||
                bus0.resp_rdata !== e.rd || bus0.resp_err !== e.err) begin
                miscompares++;
                $display("FAIL l0_resp[%0d] got valid=%b ready=%b rdata=%h err=%b, expected 1 0 %h %b",
                         i, bus0.resp_valid, bus0.req_ready, bus0.resp_rdata, bus0.resp_err, e.rd, e.err);
            end
            @(posedge clk); #1;
        end
        bus0.req_valid = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_wr_en   = 1'b0;
        bus.req_funct3  = 3'b000;
        bus.req_addr    = 32'h0;
        bus.req_wdata   = 32'h0;
        bus.resp_ready  = 1'b1;
        bus0.req_valid  = 1'b0;
        bus0.req_wr_en  = 1'b0;
        bus0.req_funct3 = 3'b000;
        bus0.req_addr   = 32'h0;
        bus0.req_wdata  = 32'h0;
        bus0.resp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_lanes();
        test_faults();
        test_backpressure();
        test_reset_wait();
        test_latency0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
